// File: rtl/mips_bus_mem_unit.sv
// rtl/mips_bus_mem_unit.sv - Avalon-MM master sequencer for N requester ports
// Byte/half/word accesses with lane steering, load extension and misalign detection.
module mips_bus_mem_unit #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_PORTS-1:0]     req_valid,
    input  logic [N_PORTS-1:0]     req_write,
    input  logic [2*N_PORTS-1:0]   req_size,
    input  logic [N_PORTS-1:0]     req_signed,
    input  logic [ADDR_W*N_PORTS-1:0] req_addr,
    input  logic [32*N_PORTS-1:0]  req_wdata,
    output logic [N_PORTS-1:0]     req_ready,
    output logic [N_PORTS-1:0]     rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_error,
    output logic                   busy,
    output logic [31:0]            address,
    output logic                   read,
    output logic                   write,
    output logic [31:0]            writedata,
    output logic [3:0]             byteenable,
    input  logic                   waitrequest,
    input  logic [31:0]            readdata
);
    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP, S_ERR} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               write_q, write_d;
    logic [1:0]         size_q, size_d;
    logic               signed_q, signed_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;

    logic               gnt_found;
    logic [IDX_W-1:0]   gnt_idx;
    logic               sel_write, sel_signed, sel_mis;
    logic [1:0]         sel_size;
    logic [31:0]        sel_addr, sel_wdata, steer_wdata;
    logic [3:0]         steer_be;
    logic [7:0]         load_byte;
    logic [15:0]        load_half;

    // Later iterations override earlier ones, so the highest valid index wins.
    always_comb begin
        gnt_found  = 1'b0;
        gnt_idx    = '0;
        sel_write  = 1'b0;
        sel_size   = 2'd0;
        sel_signed = 1'b0;
        sel_addr   = 32'd0;
        sel_wdata  = 32'd0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (req_valid[i]) begin
                gnt_found  = 1'b1;
                gnt_idx    = IDX_W'(i);
                sel_write  = req_write[i];
                sel_size   = req_size[2*i +: 2];
                sel_signed = req_signed[i];
                sel_addr   = 32'(req_addr[ADDR_W*i +: ADDR_W]);
                sel_wdata  = req_wdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        sel_mis     = 1'b0;
        steer_be    = 4'b1111;
        steer_wdata = sel_wdata;
        case (sel_size)
            2'd0: begin
                steer_be    = 4'b0001 << sel_addr[1:0];
                steer_wdata = {4{sel_wdata[7:0]}};
            end
            2'd1: begin
                sel_mis     = sel_addr[0];
                steer_be    = sel_addr[1] ? 4'b1100 : 4'b0011;
                steer_wdata = {2{sel_wdata[15:0]}};
            end
            default: sel_mis = |sel_addr[1:0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    idx_d    = gnt_idx;
                    write_d  = sel_write;
                    size_d   = sel_size;
                    signed_d = sel_signed;
                    addr_d   = sel_addr;
                    wdata_d  = steer_wdata;
                    be_d     = steer_be;
                    state_d  = sel_mis ? S_ERR : S_BUS;
                end
            end
            S_BUS:   if (!waitrequest) state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            write_q  <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            be_q     <= 4'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
        end
    end

    assign load_byte = readdata[{addr_q[1:0], 3'b000} +: 8];
    assign load_half = addr_q[1] ? readdata[31:16] : readdata[15:0];

    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_rdata  = 32'd0;
        rsp_error  = 1'b0;
        busy       = (state_q != S_IDLE);
        address    = 32'd0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = 32'd0;
        byteenable = 4'd0;
        for (int i = 0; i < N_PORTS; i++) begin
            req_ready[i] = (state_q == S_IDLE) && gnt_found && !reset && (gnt_idx == IDX_W'(i));
            rsp_valid[i] = ((state_q == S_RESP) || (state_q == S_ERR)) && (idx_q == IDX_W'(i));
        end
        case (state_q)
            S_BUS: begin
                address    = {addr_q[31:2], 2'b00};
                read       = ~write_q;
                write      = write_q;
                writedata  = wdata_q;
                byteenable = be_q;
            end
            S_RESP: begin
                if (!write_q) begin
                    case (size_q)
                        2'd0:    rsp_rdata = {{24{signed_q & load_byte[7]}}, load_byte};
                        2'd1:    rsp_rdata = {{16{signed_q & load_half[15]}}, load_half};
                        default: rsp_rdata = readdata;
                    endcase
                end
            end
            S_ERR:   rsp_error = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mips_bus_mem_unit.sv
// tb/tb_mips_bus_mem_unit.sv - randomized self-checking bench for mips_bus_mem_unit
module tb_mips_bus_mem_unit;
    localparam int NP = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   req_valid, req_write, req_signed;
    logic [2*NP-1:0] req_size;
    logic [32*NP-1:0] req_addr, req_wdata;
    logic [NP-1:0]   req_ready, rsp_valid;
    logic [31:0]     rsp_rdata, address, writedata, readdata;
    logic            rsp_error, busy, read, write, waitrequest;
    logic [3:0]      byteenable;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_bus_mem_unit #(.N_PORTS(NP), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .busy(busy), .address(address), .read(read),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] ad);
        return (ad % m_bytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] m_be(input logic [1:0] sz, input logic [31:0] ad);
        int nb = m_bytes(sz);
        if (nb == 4) return 32'd15;
        if (nb == 2) return 32'd3 << (ad & 32'd2);
        return 32'd1 << (ad & 32'd3);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        int nb = m_bytes(sz);
        if (nb == 1) return (wd & 32'hFF) * 32'h01010101;
        if (nb == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] sz, input bit sg,
                                            input logic [31:0] ad, input logic [31:0] rd);
        int nb = m_bytes(sz);
        logic [31:0] v;
        if (nb == 4) return rd;
        v = rd >> (8 * (ad % 4 - ad % nb));
        if (nb == 1) begin
            v = v % 256;
            if (sg && v >= 128) v = v - 256;
        end else begin
            v = v % 65536;
            if (sg && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int p, input bit wr, input logic [1:0] sz, input bit sg,
                           input logic [31:0] ad, input logic [31:0] wd);
        req_valid[p]        = 1'b1;
        req_write[p]        = wr;
        req_size[2*p +: 2]  = sz;
        req_signed[p]       = sg;
        req_addr[32*p +: 32]  = ad;
        req_wdata[32*p +: 32] = wd;
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
    task automatic run_txn(input int p, input bit wr, input logic [1:0] sz, input bit sg,
                           input logic [31:0] ad, input logic [31:0] wd, input int nwait,
                           input logic [31:0] rd);
        set_req(p, wr, sz, sg, ad, wd);
        #1;
        chk("busy_idle", 32'(busy), 32'd0);
        chk("grant", 32'(req_ready), 32'd1 << p);
        step();
        req_valid[p] = 1'b0;
        if (m_mis(sz, ad)) begin
            #1;
            chk("err_valid", 32'(rsp_valid), 32'd1 << p);
            chk("err_flag", 32'(rsp_error), 32'd1);
            chk("err_rdata", rsp_rdata, 32'd0);
            chk("err_strobe", 32'({read, write}), 32'd0);
            step();
        end else begin
            for (int k = 0; k <= nwait; k++) begin
                waitrequest = (k < nwait);
                #1;
                chk("read", 32'(read), 32'(!wr));
                chk("write", 32'(write), 32'(wr));
                chk("address", address, ad & 32'hFFFF_FFFC);
                chk("byteenable", 32'(byteenable), m_be(sz, ad));
                if (wr) chk("writedata", writedata, m_wdata(sz, wd));
                chk("no_rsp_in_bus", 32'(rsp_valid), 32'd0);
                chk("no_grant_in_bus", 32'(req_ready), 32'd0);
                step();
            end
            waitrequest = $urandom_range(0, 1);
            readdata = rd;
            #1;
            chk("rsp_valid", 32'(rsp_valid), 32'd1 << p);
            chk("rsp_error", 32'(rsp_error), 32'd0);
            chk("rsp_rdata", rsp_rdata, wr ? 32'd0 : m_rdata(sz, sg, ad, rd));
            chk("resp_strobe", 32'({read, write, byteenable}), 32'd0);
            step();
            readdata = $urandom;
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; req_write = '0; req_signed = '0; req_size = '0;
        req_addr = '0; req_wdata = '0;
        waitrequest = 1'b0; readdata = 32'd0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outputs", 32'({read, write, byteenable, req_ready, rsp_valid, rsp_error}), 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        reset = 1'b0;
        step();

        run_txn(0, 1'b0, 2'd2, 1'b0, 32'hBFC0_0000, 32'd0, 0, 32'h8C02_0004);
        run_txn(1, 1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'd0, 0, 32'h8000_0000);
        run_txn(1, 1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'd0, 1, 32'h8000_0000);
        run_txn(1, 1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 3, 32'd0);
        run_txn(1, 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'd0, 0, 32'd0);
        run_txn(0, 1'b0, 2'd3, 1'b0, 32'h0000_0101, 32'd0, 0, 32'd0);

        // Contention: port 0 stays pending while port 1 completes.
        set_req(0, 1'b1, 2'd2, 1'b0, 32'h0000_4000, 32'h1234_5678);
        run_txn(1, 1'b0, 2'd1, 1'b1, 32'h0000_3002, 32'd0, 1, 32'h9ABC_0000);
        run_txn(0, 1'b1, 2'd2, 1'b0, 32'h0000_4000, 32'h1234_5678, 0, 32'd0);

        // Reset during a stalled read abandons it.
        set_req(0, 1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'd0);
        step();
        req_valid[0] = 1'b0;
        waitrequest = 1'b1;
        #1;
        chk("stall_read", 32'(read), 32'd1);
        reset = 1'b1;
        step();
        chk("rst_mid_read", 32'(read), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        waitrequest = 1'b0;
        step();
        chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
        run_txn(0, 1'b0, 2'd2, 1'b0, 32'h0000_5004, 32'd0, 0, 32'hCAFE_F00D);

        for (int n = 0; n < 60; n++) begin
            run_txn($urandom_range(0, NP-1), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 3), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
